// File: rtl/seq_shifter.sv
// Sequential one-bit-per-cycle shifter: LSR, LSL, ASR and (optionally) ROR.
// Define SEQ_SHIFTER_ROTATE_EN to enable ROR on op=11; otherwise op=11 acts as LSR.
module seq_shifter #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] d_in,
   input  logic [SHW-1:0]   shamt,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] d_out,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] MODE_LSR = 2'b00;
   localparam logic [1:0] MODE_LSL = 2'b01;
   localparam logic [1:0] MODE_ASR = 2'b10;
   localparam logic [1:0] MODE_ROR = 2'b11;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [SHW-1:0]   cnt;
   logic [1:0]       mode;
   logic [WIDTH-1:0] shifted;
   logic             load;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Single-bit step for the latched mode; unknown/disabled modes fall back to LSR.
   always_comb begin
      shifted = {1'b0, d_out[WIDTH-1:1]};
      case (mode)
         MODE_LSR: shifted = {1'b0, d_out[WIDTH-1:1]};
         MODE_LSL: shifted = {d_out[WIDTH-2:0], 1'b0};
         MODE_ASR: shifted = {d_out[WIDTH-1], d_out[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
         MODE_ROR: shifted = {d_out[0], d_out[WIDTH-1:1]};
`endif
         default:  shifted = {1'b0, d_out[WIDTH-1:1]};
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_out <= '0;
         cnt   <= '0;
         mode  <= MODE_LSR;
      end else if (load) begin
         d_out <= d_in;
         cnt   <= shamt;
         mode  <= op;
      end else if (state == SHIFT && cnt != '0) begin
         d_out <= shifted;
         cnt   <= cnt - SHW'(1);
      end
   end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter (WIDTH=8): result, latency, busy/done timing and reset abort.
module tb_seq_shifter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] d_in = '0;
   logic [2:0] shamt = '0;
   logic [1:0] op = '0;
   logic [7:0] d_out;
   logic       busy, done;

   int checks = 0;
   int errors = 0;

   seq_shifter #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .d_in(d_in), .shamt(shamt),
      .op(op), .d_out(d_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge right after the start edge.
   task automatic launch(input logic [7:0] din, input logic [2:0] sh, input logic [1:0] o);
      d_in  = din;
      shamt = sh;
      op    = o;
      start = 1'b1;
      tick();
      start = 1'b0;
      d_in  = 8'hA5;
      shamt = 3'd7;
      op    = 2'b01;
   endtask

   // lat = clock edges after the start edge until done is seen.
   task automatic wait_done(input string tag, output int lat, output int bcyc);
      lat  = 0;
      bcyc = 0;
      while (!done && lat < 50) begin
         if (busy) bcyc++;
         tick();
         lat++;
      end
      if (!done) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic run_op(input string tag, input logic [7:0] din, input logic [2:0] sh,
                         input logic [1:0] o, input logic [7:0] exp);
      int lat, bcyc;
      launch(din, sh, o);
      wait_done(tag, lat, bcyc);
      check({tag, "_dout"}, d_out, exp);
      check({tag, "_lat"}, lat, sh + 1);
      check({tag, "_busy_cyc"}, bcyc, sh + 1);
      check({tag, "_busy_at_done"}, busy, 0);
      tick();
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_hold"}, d_out, exp);
   endtask

   initial begin
      int lat, bcyc;
      logic [7:0] ror_exp;
      logic saw_done;

      #1;
      check("rst_dout", d_out, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      run_op("lsr_1f", 8'h1F, 3'd3, 2'b00, 8'h03);
      run_op("asr_96", 8'h96, 3'd3, 2'b10, 8'hF2);
      run_op("lsl_81", 8'h81, 3'd1, 2'b01, 8'h02);
`ifdef SEQ_SHIFTER_ROTATE_EN
      ror_exp = 8'h18;
`else
      ror_exp = 8'h08;
`endif
      run_op("op11_81", 8'h81, 3'd4, 2'b11, ror_exp);
      run_op("zero_ff", 8'hFF, 3'd0, 2'b00, 8'hFF);

      // Second start two cycles into a shift must be ignored.
      launch(8'hFF, 3'd3, 2'b00);
      tick();
      d_in  = 8'h00;
      shamt = 3'd1;
      op    = 2'b01;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("ign", lat, bcyc);
      check("ign_dout", d_out, 8'h1F);
      check("ign_lat", lat + 2, 4);

      // Reset mid-shift aborts with no done pulse.
      launch(8'hFF, 3'd5, 2'b00);
      tick();
      reset = 1'b1;
      #1;
      check("abort_dout", d_out, 8'h00);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done || busy) saw_done = 1'b1;
         tick();
      end
      check("abort_quiet", saw_done, 0);
      run_op("post_rst_f0", 8'hF0, 3'd2, 2'b00, 8'h3C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width in bits (legal 2..64).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width in bits.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock (only clock).
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to load operands and begin a shift.
REQ-006 The block SHALL have port d_in  input  WIDTH  operand sampled on an accepted start.
REQ-007 The block SHALL have port shamt  input  SHW  shift amount sampled on an accepted start.
REQ-008 The block SHALL have port op  input  2  mode sampled on an accepted start: 00 LSR, 01 LSL, 10 ASR, 11 ROR.
REQ-009 The block SHALL have port d_out  output  WIDTH  shift register contents; final result once done has pulsed.
REQ-010 The block SHALL have port busy  output  1  high while in SHIFT.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse on completion.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL load d_out<=d_in, cnt<=shamt, mode<=op and move to SHIFT.
REQ-014 In SHIFT, start SHALL be ignored, and d_in, shamt and op SHALL have no effect.
REQ-015 In SHIFT with cnt!=0, each edge SHALL shift d_out by exactly one bit per the latched mode and decrement cnt by 1.
REQ-016 In SHIFT with cnt==0, the next edge SHALL move to DONE without shifting.
REQ-017 LSR SHALL insert 0 at the MSB; LSL SHALL insert 0 at the LSB; ASR SHALL replicate the MSB; ROR SHALL move the LSB to the MSB.
REQ-018 For start accepted at edge E0 with shamt=N, done SHALL be high only between edges E0+N+1 and E0+N+2; busy SHALL be high from E0 to E0+N+1.
REQ-019 DONE without start SHALL return to IDLE after one cycle.
REQ-020 d_out SHALL hold the result in IDLE until the next accepted start.
REQ-021 shamt=0 SHALL give d_out=d_in with done one edge after the start edge.
REQ-022 The shift count SHALL never wrap, since cnt only decrements while nonzero.
REQ-023 busy and done SHALL never be high in the same cycle.

Reset
REQ-024 reset=1 SHALL immediately force state=IDLE, d_out=0, cnt=0, mode=LSR, busy=0 and done=0, regardless of clk.
REQ-025 reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-026 After reset deasserts, the first start SHALL be accepted normally.

Configuration
REQ-027 With macro SEQ_SHIFTER_ROTATE_EN defined, op=11 SHALL perform ROR.
REQ-028 Without SEQ_SHIFTER_ROTATE_EN, op=11 SHALL be treated as LSR, and no rotate logic SHALL be present.

Verification (WIDTH=8; each check made when done=1)
REQ-029 The bench SHALL cover: d_in=8'h1F, shamt=3, op=LSR -> d_out=8'h03, with done 4 edges after the start edge.
REQ-030 The bench SHALL cover: d_in=8'h96, shamt=3, op=ASR -> d_out=8'hF2; then d_in=8'h81, shamt=1, op=LSL -> d_out=8'h02.
REQ-031 The bench SHALL cover: d_in=8'h81, shamt=4, op=11 -> d_out=8'h18 with SEQ_SHIFTER_ROTATE_EN defined, and 8'h08 without it.
REQ-032 The bench SHALL cover: d_in=8'hFF, shamt=0, op=LSR -> d_out=8'hFF, with done high exactly one cycle and busy high for 1 cycle.
REQ-033 The bench SHALL cover: second start with d_in=8'h00 two cycles into an 8'hFF, shamt=3, LSR shift -> ignored, and d_out=8'h1F.
REQ-034 The bench SHALL cover: reset pulsed during SHIFT -> d_out=0, busy=0, no done pulse; a following start with 8'hF0, shamt=2, LSR -> 8'h3C.
